// File: rtl/mux16_scan_ctrl_pkg.sv
// mux16_scan_pkg: shared types and constants for the 16:1 mux scan sequencer.
//   NCH  - number of mux channels scanned per word
//   SELW - width of the mux select
//   CNTW - width of the settle counter
//   scan_state_e - sequencer FSM states
package mux16_scan_pkg;

   localparam int NCH  = 16;
   localparam int SELW = 4;
   localparam int CNTW = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_HOLD   = 2'd3
   } scan_state_e;

   // True when the select points at the final channel of a scan.
   function automatic logic is_last_ch(input logic [SELW-1:0] s);
      return (s == 4'd15);
   endfunction

endpackage

// File: rtl/mux16_scan_ctrl_if.sv
// mux16_scan_ctrl_if: bundle between the scan sequencer, the mux and the word consumer.
//   start    - scan request (sampled only while idle)
//   sel      - mux select driven by the sequencer
//   mux_in   - single-bit mux output, combinational from sel
//   busy     - scan or hold in progress
//   data_out - assembled word, bit i = channel i sample
//   valid    - data_out holds a new word
//   ready    - consumer accepts the word when valid && ready
// master: the sequencer side; slave: the environment (mux + requester + consumer).
interface mux16_scan_ctrl_if;
   import mux16_scan_pkg::*;

   logic            start;
   logic [SELW-1:0] sel;
   logic            mux_in;
   logic            busy;
   logic [NCH-1:0]  data_out;
   logic            valid;
   logic            ready;

   modport master (
      input  start, mux_in, ready,
      output sel, busy, data_out, valid
   );

   modport slave (
      output start, mux_in, ready,
      input  sel, busy, data_out, valid
   );

endinterface

// File: rtl/mux16_scan_ctrl_settle_cnt.sv
// scan_settle_cnt: loadable down-counter with a zero flag, used to time settle intervals.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - load load_val_i (has priority over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement by one; holds at zero
//   zero_o      - count is zero
module scan_settle_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load wins, otherwise decrement without wrapping below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: steps a 16:1 mux select through channels 0..15, samples the mux
// output after SETTLE extra cycles per channel, assembles a 16-bit word and hands it
// over with valid/ready.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; an interrupted scan is discarded
//   bus   - mux16_scan_ctrl_if master modport (start/sel/mux_in/busy/data_out/valid/ready)
// Parameter SETTLE (0..15): extra wait cycles between a select change and its sample.
module mux16_scan_ctrl
   import mux16_scan_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux16_scan_ctrl_if.master     bus
);

   localparam logic [CNTW-1:0] SETTLE_V = CNTW'(SETTLE);

   scan_state_e     state_q;
   scan_state_e     state_d;
   logic [SELW-1:0] sel_q;
   logic [NCH-1:0]  shadow_q;
   logic [NCH-1:0]  data_q;
   logic            valid_q;

   logic            cnt_zero_s;
   logic            cnt_load_s;
   logic            cnt_dec_s;
   logic            scan_go_s;
   logic            sample_s;
   logic            handoff_s;
   logic            accept_s;
   logic            last_ch_s;

   assign last_ch_s = is_last_ch(sel_q);

   scan_settle_cnt #(.W(CNTW)) u_settle_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load_s),
      .load_val_i (SETTLE_V),
      .dec_i      (cnt_dec_s),
      .zero_o     (cnt_zero_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_SETTLE;
            else           state_d = ST_IDLE;
         end
         ST_SETTLE: begin
            // The counter is checked before it decrements, so SETTLE lasts SETTLE+1 cycles.
            if (cnt_zero_s) state_d = ST_SAMPLE;
            else            state_d = ST_SETTLE;
         end
         ST_SAMPLE: begin
            if (last_ch_s) state_d = ST_HOLD;
            else           state_d = ST_SETTLE;
         end
         ST_HOLD: begin
            if (valid_q && bus.ready) state_d = ST_IDLE;
            else                      state_d = ST_HOLD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM output decode: one-cycle control strobes for counter and datapath.
   always_comb begin
      scan_go_s  = 1'b0;
      sample_s   = 1'b0;
      handoff_s  = 1'b0;
      accept_s   = 1'b0;
      cnt_dec_s  = 1'b0;
      case (state_q)
         ST_IDLE:   scan_go_s = bus.start;
         ST_SETTLE: cnt_dec_s = 1'b1;
         ST_SAMPLE: begin
            sample_s  = 1'b1;
            handoff_s = last_ch_s;
         end
         ST_HOLD:   accept_s = valid_q & bus.ready;
         default: begin
            scan_go_s = 1'b0;
         end
      endcase
      cnt_load_s = scan_go_s | (sample_s & ~last_ch_s);
   end

   // Datapath: select stepping, shadow capture and word handoff.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (scan_go_s) begin
            sel_q <= '0;
         end else if (sample_s && !last_ch_s) begin
            sel_q <= sel_q + 4'd1;
         end else begin
            sel_q <= sel_q;
         end

         if (sample_s) begin
            shadow_q[sel_q] <= bus.mux_in;
         end else begin
            shadow_q <= shadow_q;
         end

         // The channel-15 bit is taken straight from the mux since the shadow
         // bit is only written at this same edge.
         if (handoff_s) begin
            data_q  <= {bus.mux_in, shadow_q[NCH-2:0]};
            valid_q <= 1'b1;
         end else if (accept_s) begin
            data_q  <= data_q;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_q;
            valid_q <= valid_q;
         end
      end
   end

   assign bus.sel      = sel_q;
   assign bus.data_out = data_q;
   assign bus.valid    = valid_q;
   assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: one instance with SETTLE=1 and one with SETTLE=0,
// sharing a behavioural 16:1 mux model driven from a_word.
module tb_mux16_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a_word = 16'h0000;
   logic        go = 1'b0;
   logic        rdy = 1'b1;
   logic        dsel = 1'b0;   // 0: drive/observe the SETTLE=1 instance, 1: SETTLE=0

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] last_word = 16'h0000;

   always #5 clk = ~clk;

   mux16_scan_ctrl_if if1 ();
   mux16_scan_ctrl_if if0 ();

   assign if1.start  = go & ~dsel;
   assign if0.start  = go & dsel;
   assign if1.ready  = dsel ? 1'b1 : rdy;
   assign if0.ready  = dsel ? rdy : 1'b1;
   assign if1.mux_in = a_word[if1.sel];
   assign if0.mux_in = a_word[if0.sel];

   mux16_scan_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
   mux16_scan_ctrl #(.SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));

   wire [3:0]  o_sel   = dsel ? if0.sel      : if1.sel;
   wire        o_busy  = dsel ? if0.busy     : if1.busy;
   wire        o_valid = dsel ? if0.valid    : if1.valid;
   wire [15:0] o_data  = dsel ? if0.data_out : if1.data_out;

   // Settle monitor: every mid-scan select step must follow exactly SETTLE+2 cycles on the old value.
   int         held1 = 0, held0 = 0;
   logic [3:0] prev1 = 4'd0, prev0 = 4'd0;
   logic       pb1 = 1'b0, pb0 = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         held1 = 0; prev1 = 4'd0; pb1 = 1'b0;
         held0 = 0; prev0 = 4'd0; pb0 = 1'b0;
      end else begin
         if (if1.busy && !pb1) held1 = 1;
         else if (if1.sel != prev1) begin
            if (prev1 != 4'd15 && if1.sel == prev1 + 4'd1) begin
               total++;
               if (held1 != 3) begin
                  bad++;
                  $display("FAIL settle1 sel=%0d held=%0d want=3", prev1, held1);
               end
            end
            held1 = 1;
         end else held1++;
         prev1 = if1.sel; pb1 = if1.busy;

         if (if0.busy && !pb0) held0 = 1;
         else if (if0.sel != prev0) begin
            if (prev0 != 4'd15 && if0.sel == prev0 + 4'd1) begin
               total++;
               if (held0 != 2) begin
                  bad++;
                  $display("FAIL settle0 sel=%0d held=%0d want=2", prev0, held0);
               end
            end
            held0 = 1;
         end else held0++;
         prev0 = if0.sel; pb0 = if0.busy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one full scan on the selected instance with the scoreboard word queued at start.
   task automatic do_scan(input logic [15:0] word, input int hold, input bit start_mid,
                          input bit start_hs, input bit check_after);
      int          per;
      int          lat;
      logic [15:0] exp;
      per = dsel ? 2 : 3;
      lat = 16 * per;
      a_word = word;
      rdy = (hold == 0);
      exp_q.push_back(word);
      go = 1'b1;
      tick();
      go = 1'b0;
      for (int k = 0; k < lat; k++) begin
         total++;
         if (o_sel !== 4'(k / per) || o_busy !== 1'b1 || o_valid !== 1'b0 || o_data !== last_word) begin
            bad++;
            $display("FAIL scan_step k=%0d sel=%0d busy=%b valid=%b data=%h want sel=%0d busy=1 valid=0 data=%h",
                     k, o_sel, o_busy, o_valid, o_data, k / per, last_word);
         end
         go = (start_mid && k == 10);
         tick();
      end
      go = 1'b0;
      exp = exp_q.pop_front();
      total++;
      if (o_valid !== 1'b1 || o_data !== exp || o_sel !== 4'd15 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL latency valid=%b data=%h sel=%0d busy=%b want valid=1 data=%h sel=15 busy=1",
                  o_valid, o_data, o_sel, o_busy, exp);
      end
      for (int h = 0; h < hold; h++) begin
         tick();
         total++;
         if (o_valid !== 1'b1 || o_data !== exp || o_sel !== 4'd15 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL hold h=%0d valid=%b data=%h sel=%0d want valid=1 data=%h sel=15",
                     h, o_valid, o_data, o_sel, exp);
         end
      end
      rdy = 1'b1;
      go = start_hs;
      tick();
      go = 1'b0;
      total++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== exp || o_sel !== 4'd15) begin
         bad++;
         $display("FAIL handshake valid=%b busy=%b data=%h sel=%0d want valid=0 busy=0 data=%h sel=15",
                  o_valid, o_busy, o_data, o_sel, exp);
      end
      last_word = exp;
      if (check_after) begin
         for (int j = 0; j < 5; j++) begin
            tick();
            total++;
            if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_sel !== 4'd15) begin
               bad++;
               $display("FAIL no_rescan j=%0d busy=%b valid=%b sel=%0d want busy=0 valid=0 sel=15",
                        j, o_busy, o_valid, o_sel);
            end
         end
      end
   endtask

   task automatic test_reset();
      tick();
      total++;
      if (if1.sel !== 4'd0 || if1.busy !== 1'b0 || if1.valid !== 1'b0 || if1.data_out !== 16'h0000 ||
          if0.sel !== 4'd0 || if0.busy !== 1'b0 || if0.valid !== 1'b0 || if0.data_out !== 16'h0000) begin
         bad++;
         $display("FAIL reset sel=%0d/%0d busy=%b/%b valid=%b/%b data=%h/%h want all 0",
                  if1.sel, if0.sel, if1.busy, if0.busy, if1.valid, if0.valid, if1.data_out, if0.data_out);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      dsel = 1'b0;
      do_scan(16'hA5C3, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      dsel = 1'b0;
      do_scan(16'h5A3C, 20, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_ignored_start();
      dsel = 1'b0;
      do_scan(16'h0F0F, 3, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid();
      dsel = 1'b0;
      a_word = 16'hFFFF;
      go = 1'b1;
      tick();
      go = 1'b0;
      repeat (22) tick();
      total++;
      if (o_sel !== 4'd7 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset sel=%0d busy=%b want sel=7 busy=1", o_sel, o_busy);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (o_sel !== 4'd0 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_data !== 16'h0000) begin
         bad++;
         $display("FAIL async_reset sel=%0d busy=%b valid=%b data=%h want all 0",
                  o_sel, o_busy, o_valid, o_data);
      end
      tick();
      rst_n = 1'b1;
      last_word = 16'h0000;
      for (int j = 0; j < 60; j++) begin
         tick();
         total++;
         if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset j=%0d valid=%b busy=%b want 0/0", j, o_valid, o_busy);
         end
      end
   endtask

   task automatic test_settle0();
      dsel = 1'b1;
      do_scan(16'h0001, 0, 1'b0, 1'b0, 1'b0);
      do_scan(16'hFFFF, 0, 1'b0, 1'b0, 1'b1);
      dsel = 1'b0;
      last_word = 16'h0000;
   endtask

   task automatic test_back_to_back();
      dsel = 1'b0;
      do_scan(16'h1234, 0, 1'b0, 1'b0, 1'b0);
      do_scan(16'h8000, 0, 1'b0, 1'b0, 1'b0);
      do_scan(16'h0000, 0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_ignored_start();
      test_reset_mid();
      test_settle0();
      test_back_to_back();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left size=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
